// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory-stage access unit (master) and data memory (slave).
// A request is held until a single-cycle ack completes it.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [31:0]           bus_wdata;
  logic [31:0]           bus_rdata;
  logic                  bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );

endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage lw/sw engine: one req/ack bus transaction per instruction, stalling upstream meanwhile.
// Optional bus timeout abort is built only when MEM_TIMEOUT_EN is defined.
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           store_data_i,
  output logic [31:0]           mem_out_o,
  output logic                  stall_o,
  output logic                  misalign_err_o,
  output logic                  bus_err_o,
  mem_access_unit_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q;
  logic                  bus_req_q;
  logic                  bus_we_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [31:0]           bus_wdata_q;
  logic [31:0]           mem_out_q;
  logic                  misalign_q;

  logic start;
  logic aligned;

  assign start   = mem_read_i | mem_write_i;
  assign aligned = (addr_i[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             bus_err_q;

  // Count of BUSY cycles seen so far, including the current one.
  assign cnt_d     = cnt_q + 1'b1;
  assign bus_err_o = bus_err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign bus_err_o      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      mem_out_q   <= '0;
      misalign_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (aligned) begin
              bus_addr_q  <= addr_i;
              bus_wdata_q <= store_data_i;
              bus_we_q    <= mem_write_i;
              bus_req_q   <= 1'b1;
`ifdef MEM_TIMEOUT_EN
              cnt_q       <= '0;
`endif
              state_q     <= BUSY;
            end else begin
              misalign_q <= 1'b1;
              state_q    <= DONE;
            end
          end
        end

        BUSY: begin
          // An ack arriving together with the limit still completes normally.
          if (bus.bus_ack) begin
            bus_req_q <= 1'b0;
            if (!bus_we_q) begin
              mem_out_q <= bus.bus_rdata;
            end
            state_q <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt_d == CNT_LIMIT) begin
            bus_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
`endif
        end

        DONE: begin
          misalign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          bus_err_q  <= 1'b0;
`endif
          state_q    <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stall_o        = ((state_q == IDLE) && start) || (state_q == BUSY);
  assign mem_out_o      = mem_out_q;
  assign misalign_err_o = misalign_q;

  assign bus.bus_req    = bus_req_q;
  assign bus.bus_we     = bus_we_q;
  assign bus.bus_addr   = bus_addr_q;
  assign bus.bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit against a transaction-level model of stall/bus/load behaviour.
// Timeout scenarios are exercised when MEM_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int AW = 32;
  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read_i = 1'b0;
  logic          mem_write_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [31:0]   store_data_i = '0;
  logic [31:0]   mem_out_o;
  logic          stall_o;
  logic          misalign_err_o;
  logic          bus_err_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_mem = '0;

  mem_access_unit_if #(.ADDR_WIDTH(AW)) bus_if ();

  mem_access_unit #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_read_i    (mem_read_i),
    .mem_write_i   (mem_write_i),
    .addr_i        (addr_i),
    .store_data_i  (store_data_i),
    .mem_out_o     (mem_out_o),
    .stall_o       (stall_o),
    .misalign_err_o(misalign_err_o),
    .bus_err_o     (bus_err_o),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge with the unit idle. n = BUSY cycle on which ack is given (0 = never).
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input int n, input logic [31:0] rdata);
    bit start;
    bit aligned;
    bit exp_to;
    bit done;
    int exp_busy;
    int exp_stall;
    int stall_cnt;
    int req_cnt;
    start     = rd | wr;
    aligned   = (a % 4) == 0;
    exp_to    = 1'b0;
    done      = 1'b0;
    stall_cnt = 0;
    req_cnt   = 0;
    if (!start || !aligned) exp_busy = 0;
    else if (TO_EN && (n == 0 || n > TO)) begin
      exp_busy = TO;
      exp_to   = 1'b1;
    end else exp_busy = n;
    exp_stall = start ? 1 + exp_busy : 0;

    mem_read_i   = rd;
    mem_write_i  = wr;
    addr_i       = a;
    store_data_i = d;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      if (stall_o) stall_cnt++;
      if (bus_if.bus_req) begin
        req_cnt++;
        check("bus_we", {31'd0, bus_if.bus_we}, {31'd0, wr});
        check("bus_addr", bus_if.bus_addr, a);
        if (wr) check("bus_wdata", bus_if.bus_wdata, d);
        if (req_cnt == n) begin
          bus_if.bus_ack   = 1'b1;
          bus_if.bus_rdata = rdata;
        end
      end
      if (!stall_o) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = $urandom;
      end
    end
    check("done_reached", {31'd0, done}, 32'd1);
    check("stall_cycles", stall_cnt, exp_stall);
    check("req_cycles", req_cnt, exp_busy);
    check("misalign_pulse", {31'd0, misalign_err_o}, {31'd0, start && !aligned});
    check("bus_err_pulse", {31'd0, bus_err_o}, {31'd0, exp_to});
    if (start && aligned && !wr && !exp_to) model_mem = rdata;
    check("mem_out_done", mem_out_o, model_mem);
    $display("txn rd=%0d wr=%0d addr=%h n=%0d stall=%0d req=%0d err=%0d mem_out=%h",
             rd, wr, a, n, stall_cnt, req_cnt, bus_err_o, mem_out_o);

    // Following idle cycle with a stray ack: pulses gone, nothing changes.
    @(posedge clk);
    #1;
    mem_read_i       = 1'b0;
    mem_write_i      = 1'b0;
    addr_i           = $urandom;
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = $urandom;
    @(negedge clk);
    check("idle_stall", {31'd0, stall_o}, 32'd0);
    check("idle_req", {31'd0, bus_if.bus_req}, 32'd0);
    check("idle_misalign", {31'd0, misalign_err_o}, 32'd0);
    check("idle_bus_err", {31'd0, bus_err_o}, 32'd0);
    @(posedge clk);
    #1;
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_mem_out", mem_out_o, model_mem);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    int          rn;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;

    #12;
    check("rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
    check("rst_bus_we", {31'd0, bus_if.bus_we}, 32'd0);
    check("rst_bus_addr", bus_if.bus_addr, 32'd0);
    check("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
    check("rst_mem_out", mem_out_o, 32'd0);
    check("rst_misalign", {31'd0, misalign_err_o}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hCAFEF00D);
    run_txn(1'b0, 1'b1, 32'h204, 32'h12345678, 5, 32'hDEADBEEF);
    run_txn(1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h11111111);
    run_txn(1'b1, 1'b1, 32'h10, 32'hA5A55A5A, 2, 32'h22222222);
    run_txn(1'b0, 1'b0, 32'h20, 32'h0, 1, 32'h33333333);

    // Reset in the middle of a BUSY phase.
    mem_read_i = 1'b1;
    addr_i     = 32'h40;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_req", {31'd0, bus_if.bus_req}, 32'd1);
    rst_n      = 1'b0;
    mem_read_i = 1'b0;
    #1;
    check("midrst_req", {31'd0, bus_if.bus_req}, 32'd0);
    check("midrst_stall", {31'd0, stall_o}, 32'd0);
    check("midrst_mem_out", mem_out_o, 32'd0);
    model_mem = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h77777777;
    @(posedge clk);
    #1;
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    check("late_ack_mem_out", mem_out_o, 32'd0);
    check("late_ack_req", {31'd0, bus_if.bus_req}, 32'd0);
    check("late_ack_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;

`ifdef MEM_TIMEOUT_EN
    run_txn(1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h44444444);
    run_txn(1'b1, 1'b0, 32'h300, 32'h0, TO, 32'h55555555);
    run_txn(1'b0, 1'b1, 32'h304, 32'h66666666, TO + 1, 32'h0);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 2) != 0) ra[1:0] = 2'b00;
      rn = TO_EN ? int'($urandom_range(0, 6)) : int'($urandom_range(1, 6));
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom, rn, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store engine. Takes lw/sw requests from the execute stage and runs a req/ack transaction on the data-memory bus.
- Stalls the pipeline while a transaction is in flight.
- Presents registered load data on mem_out, which the write-back select stage consumes.
- Sits between the execute-stage ALU result and write-back.

Parameters:
ADDR_WIDTH, 32, width of addr/bus_addr in bits
TIMEOUT_CYCLES, 16, BUSY cycles without bus_ack before abort (used only when MEM_TIMEOUT_EN is defined; minimum 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
mem_read  input  1  current instruction is lw
mem_write  input  1  current instruction is sw
addr  input  ADDR_WIDTH  byte address from ALU
store_data  input  32  sw data
mem_out  output  32  last completed load data, registered
stall  output  1  hold upstream pipeline stages
misalign_err  output  1  one-cycle pulse: access aborted, addr[1:0] != 0
bus_err  output  1  one-cycle pulse: access aborted on timeout (0 without MEM_TIMEOUT_EN)
bus_req  output  1  bus request, registered
bus_we  output  1  1 = write, 0 = read, registered
bus_addr  output  ADDR_WIDTH  bus address, registered
bus_wdata  output  32  bus write data, registered
bus_rdata  input  32  bus read data, valid when bus_ack=1
bus_ack  input  1  transaction complete, single-cycle pulse

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all registered outputs 0 (bus_req, bus_we, bus_addr, bus_wdata, mem_out, misalign_err, bus_err); state IDLE.
- Definitions: start = mem_read | mem_write. If both are high, treat as a write.
- stall = (state==IDLE & start) | (state==BUSY). stall is 0 in DONE. It is combinational from state and inputs.
- IDLE:
  - If start and addr[1:0]==0: latch addr into bus_addr, store_data into bus_wdata, set bus_we=mem_write, set bus_req=1, go to BUSY.
  - If start and addr[1:0]!=0: no bus activity, set misalign_err=1, go to DONE.
  - Otherwise stay in IDLE.
- BUSY:
  - bus_req is held at 1 with stable bus_addr, bus_we and bus_wdata until bus_ack.
  - On bus_ack: bus_req←0. If the access is a read, mem_out←bus_rdata. Go to DONE.
- DONE:
  - Lasts exactly one cycle; stall=0 so the instruction leaves the stage at the end of this cycle.
  - misalign_err and bus_err clear on exit. Go to IDLE unconditionally.
  - The next instruction is evaluated in IDLE on the following cycle.
- Latency:
  - Minimum 3 cycles from a request appearing to stall dropping (IDLE → BUSY with ack in the first BUSY cycle → DONE).
  - Load data is valid on mem_out in the DONE cycle.
- mem_out holds its value until the next successful read. Writes, misaligned accesses and timeouts leave it unchanged.
- bus_ack seen in IDLE or DONE is ignored.
- Reset mid-transaction: the FSM returns to IDLE and bus_req drops immediately (asynchronous). A late bus_ack after reset is ignored.
- Inputs mem_read, mem_write, addr and store_data are sampled only in IDLE. Changes during BUSY have no effect.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to BUSY and increments each BUSY cycle without bus_ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack: bus_req←0, bus_err←1, go to DONE, mem_out unchanged.
  - An ack in the same cycle as the counter reaching the limit wins: normal completion, no error.
- Not defined:
  - No counter is built; BUSY waits indefinitely.
  - bus_err is tied to 0.

Test Plan:
- Reset, then lw addr=0x100; bus_ack on the first BUSY cycle with rdata=0xCAFEF00D → bus_req high 1 cycle with bus_we=0 and bus_addr=0x100; stall high 2 cycles; mem_out=0xCAFEF00D in DONE.
- sw addr=0x204 data=0x12345678, ack delayed 5 cycles → bus_we=1, bus_wdata=0x12345678 held stable for 5 cycles; stall high 6 cycles; mem_out unchanged from prior load.
- lw addr=0x102 → no bus_req; misalign_err pulses in the DONE cycle; stall high 1 cycle; mem_out unchanged.
- mem_read and mem_write both high at addr=0x10 → bus transaction with bus_we=1.
- Assert rst_n=0 mid-BUSY, then a stray bus_ack after release → bus_req drops in the same cycle as reset; state IDLE; mem_out=0; the stray ack has no effect.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, lw with no ack → bus_req drops after 4 BUSY cycles; bus_err pulses 1 cycle. Same test with ack on the 4th cycle → normal completion, bus_err=0.
